// File: rtl/Parameters.sv
// Shared LZSS definitions used by the bit packer and the encoder.
//   DEFAULT_OFFSET_BITS / DEFAULT_LENGTH_BITS / DEFAULT_MIN_MATCH :
//     default match field geometry.
//   LITERAL_BITS   : size of an encoded literal (flag + byte).
//   packer_state_e : bit packer FSM states.
//   max_token_bits : widest token the packer may be asked to append.
package Parameters;

  localparam int DEFAULT_OFFSET_BITS = 6;
  localparam int DEFAULT_LENGTH_BITS = 3;
  localparam int DEFAULT_MIN_MATCH   = 4;
  localparam int LITERAL_BITS        = 9;

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } packer_state_e;

  function automatic int max_token_bits(input int offset_bits, input int length_bits);
    int match_bits;
    match_bits = 1 + offset_bits + length_bits;
    return (match_bits > LITERAL_BITS) ? match_bits : LITERAL_BITS;
  endfunction

endpackage

// File: rtl/lzss_token_format.sv
// Combinational token encoder for the LZSS bit packer.
// Ports:
//   data_in    : {length[7:0], offset[15:0]} for a match, literal byte in [7:0]
//   literal    : 1 = literal token, 0 = match token
//   token_bits : encoded token, left-justified (first bit at the MSB)
//   token_len  : number of valid bits in token_bits
//   illegal    : match length or offset cannot be represented
module lzss_token_format
  import Parameters::*;
#(
  parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS,
  parameter int LENGTH_BITS = DEFAULT_LENGTH_BITS,
  parameter int MIN_MATCH   = DEFAULT_MIN_MATCH,
  parameter int TOK_W       = max_token_bits(DEFAULT_OFFSET_BITS, DEFAULT_LENGTH_BITS),
  parameter int LEN_W       = 7
) (
  input  logic [23:0]      data_in,
  input  logic             literal,
  output logic [TOK_W-1:0] token_bits,
  output logic [LEN_W-1:0] token_len,
  output logic             illegal
);

  localparam int MATCH_W = 1 + OFFSET_BITS + LENGTH_BITS;
  localparam logic [7:0] MIN_LEN = 8'(MIN_MATCH);
  localparam logic [7:0] MAX_LEN = 8'(MIN_MATCH + (1 << LENGTH_BITS) - 1);

  logic [7:0]             length;
  logic [15:0]            offset;
  logic [LENGTH_BITS-1:0] biased;

  assign length = data_in[23:16];
  assign offset = data_in[15:0];
  assign biased = LENGTH_BITS'(length - MIN_LEN);

  // Tokens are left-justified so the packer can place them with a single
  // right shift by the current fill level.
  always_comb begin
    token_bits = '0;
    token_len  = '0;
    illegal    = 1'b0;
    if (literal) begin
      token_bits = TOK_W'({1'b1, data_in[7:0]}) << (TOK_W - LITERAL_BITS);
      token_len  = LEN_W'(LITERAL_BITS);
    end else begin
      token_bits = TOK_W'({1'b0, offset[OFFSET_BITS-1:0], biased}) << (TOK_W - MATCH_W);
      token_len  = LEN_W'(MATCH_W);
      illegal    = (length < MIN_LEN) || (length > MAX_LEN) || (|(offset >> OFFSET_BITS));
    end
  end

endmodule

// File: rtl/lzss_bit_packer.sv
// Packs LZSS literal/match tokens into an MSB-first stream of fixed-width words.
// Ports:
//   clk, rst_   : clock, asynchronous active-low reset
//   data_in, literal, data_valid, in_ready : token input (no stall on encoder side)
//   flush       : pad and emit the final partial word
//   word_out, word_valid, word_ready       : packed word output handshake
//   flush_done  : one-cycle pulse once a flush has fully drained
//   err         : sticky, [0] token dropped on overflow, [1] illegal match
module lzss_bit_packer
  import Parameters::*;
#(
  parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS,
  parameter int LENGTH_BITS = DEFAULT_LENGTH_BITS,
  parameter int MIN_MATCH   = DEFAULT_MIN_MATCH,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [23:0]           data_in,
  input  logic                  literal,
  input  logic                  data_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  flush_done,
  output logic [1:0]            err
);

  localparam int ACC_W  = 2 * WORD_WIDTH;
  localparam int FILL_W = $clog2(ACC_W) + 1;
  localparam int TOK_W  = max_token_bits(OFFSET_BITS, LENGTH_BITS);
  localparam logic [FILL_W-1:0] READY_LIMIT = FILL_W'(ACC_W - TOK_W);
  localparam logic [FILL_W-1:0] WORD_FILL   = FILL_W'(WORD_WIDTH);

  packer_state_e     state, state_next;
  logic [ACC_W-1:0]  acc, acc_next, acc_merged;
  logic [FILL_W-1:0] fill, fill_next, fill_merged;
  logic [1:0]        err_next;
  logic [TOK_W-1:0]  token_bits;
  logic [FILL_W-1:0] token_len;
  logic              illegal;
  logic              token_accept, token_append, word_xfer;

  lzss_token_format #(
    .OFFSET_BITS (OFFSET_BITS),
    .LENGTH_BITS (LENGTH_BITS),
    .MIN_MATCH   (MIN_MATCH),
    .TOK_W       (TOK_W),
    .LEN_W       (FILL_W)
  ) u_token_format (
    .data_in    (data_in),
    .literal    (literal),
    .token_bits (token_bits),
    .token_len  (token_len),
    .illegal    (illegal)
  );

  // rst_ is folded in so in_ready reads 0 while reset is held, yet rises
  // immediately on release without waiting for a clock edge.
  assign in_ready     = rst_ && (state == PACK) && (fill <= READY_LIMIT);
  assign token_accept = data_valid && in_ready;
  assign token_append = token_accept && !illegal;

  // Unused accumulator bits are always zero, so a partial word in FLUSH is
  // already zero-padded on its LSB side.
  assign word_valid = ((state == PACK) && (fill >= WORD_FILL)) ||
                      ((state == FLUSH) && (fill != '0));
  assign word_out   = acc[ACC_W-1 -: WORD_WIDTH];
  assign word_xfer  = word_valid && word_ready;
  assign flush_done = (state == DRAIN);

  // Append first (below the oldest bits), then retire a word; doing both in
  // one cycle keeps a continuous stream lossless.
  always_comb begin
    acc_merged  = acc;
    fill_merged = fill;
    if (token_append) begin
      acc_merged  = acc | ((ACC_W'(token_bits) << (ACC_W - TOK_W)) >> fill);
      fill_merged = fill + token_len;
    end

    acc_next  = acc_merged;
    fill_next = fill_merged;
    if (word_xfer) begin
      acc_next  = acc_merged << WORD_WIDTH;
      fill_next = (fill_merged >= WORD_FILL) ? fill_merged - WORD_FILL : '0;
    end

    err_next = err;
    if (data_valid && !in_ready) err_next[0] = 1'b1;
    if (token_accept && illegal) err_next[1] = 1'b1;

    state_next = state;
    case (state)
      PACK: begin
        if (flush) state_next = (fill_next == '0) ? DRAIN : FLUSH;
      end
      FLUSH: begin
        if (fill_next == '0) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = PACK;
        acc_next   = '0;
        fill_next  = '0;
      end
      default: state_next = PACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= PACK;
      acc   <= '0;
      fill  <= '0;
      err   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      fill  <= fill_next;
      err   <= err_next;
    end
  end

endmodule
